// File: rtl/riskv.sv
// riskv: multi-cycle RV32I core with Wishbone B4 classic iBus and dBus masters.
// Ports: clk, rst (async high), iBus*/dBus* Wishbone masters, externalResetVector (boot word addr).
module riskv (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] iBusWishbone_ADR,
  output logic [31:0] iBusWishbone_DAT_MOSI,
  output logic [3:0]  iBusWishbone_SEL,
  output logic        iBusWishbone_CYC,
  output logic        iBusWishbone_STB,
  output logic        iBusWishbone_WE,
  output logic [2:0]  iBusWishbone_CTI,
  output logic [1:0]  iBusWishbone_BTE,
  input  logic [31:0] iBusWishbone_DAT_MISO,
  input  logic        iBusWishbone_ACK,
  input  logic        iBusWishbone_ERR,
  output logic [29:0] dBusWishbone_ADR,
  output logic [31:0] dBusWishbone_DAT_MOSI,
  output logic [3:0]  dBusWishbone_SEL,
  output logic        dBusWishbone_CYC,
  output logic        dBusWishbone_STB,
  output logic        dBusWishbone_WE,
  output logic [2:0]  dBusWishbone_CTI,
  output logic [1:0]  dBusWishbone_BTE,
  input  logic [31:0] dBusWishbone_DAT_MISO,
  input  logic        dBusWishbone_ACK,
  input  logic        dBusWishbone_ERR,
  input  logic [29:0] externalResetVector
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [6:0]  OP_AUIPC = 7'h17;
  localparam logic [6:0]  OP_JAL   = 7'h6F;
  localparam logic [6:0]  OP_JALR  = 7'h67;
  localparam logic [6:0]  OP_BR    = 7'h63;
  localparam logic [6:0]  OP_LD    = 7'h03;
  localparam logic [6:0]  OP_ST    = 7'h23;
  localparam logic [6:0]  OP_IMM   = 7'h13;
  localparam logic [6:0]  OP_REG   = 7'h33;

  typedef enum logic [1:0] {
    FETCH,
    EXECUTE,
    MEM
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regs [0:31];
  logic        i_req;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_adr;
  logic [3:0]  d_sel;
  logic [31:0] d_dat;
  logic [1:0]  ea_lo;

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1v;
  logic [31:0] rs2v;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [4:0]  shamt;
  logic        alt;
  logic        reg_ok;
  logic        imm_ok;
  logic        ld_ok;
  logic        st_ok;
  logic        br_ok;
  logic        br_take;

  logic        wb_en;
  logic [31:0] wb_val;
  logic [31:0] pc_nx;
  logic        mem_go;
  logic        mem_we;
  logic [31:0] ea;
  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        i_done;
  logic        d_done;

  // Bus outputs
  assign iBusWishbone_ADR      = rst ? externalResetVector : pc[31:2];
  assign iBusWishbone_DAT_MOSI = '0;
  assign iBusWishbone_SEL      = 4'hF;
  assign iBusWishbone_CYC      = i_req;
  assign iBusWishbone_STB      = i_req;
  assign iBusWishbone_WE       = 1'b0;
  assign iBusWishbone_CTI      = 3'b000;
  assign iBusWishbone_BTE      = 2'b00;
  assign dBusWishbone_ADR      = d_adr;
  assign dBusWishbone_DAT_MOSI = d_dat;
  assign dBusWishbone_SEL      = d_sel;
  assign dBusWishbone_CYC      = d_req;
  assign dBusWishbone_STB      = d_req;
  assign dBusWishbone_WE       = d_we;
  assign dBusWishbone_CTI      = 3'b000;
  assign dBusWishbone_BTE      = 2'b00;

  // Termination only counts while our strobe is up
  assign i_done = i_req && (iBusWishbone_ACK || iBusWishbone_ERR);
  assign d_done = d_req && (dBusWishbone_ACK || dBusWishbone_ERR);

  // Decode fields
  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign f7    = ir[31:25];
  assign rs1v  = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2v  = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  // Encoding legality; anything else falls through as NOP
  assign reg_ok = (f7 == 7'h00) ||
                  (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign imm_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) :
                  1'b1;
  assign ld_ok  = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
  assign st_ok  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
  assign br_ok  = (f3 != 3'd2) && (f3 != 3'd3);

  // ALU
  always_comb begin
    alu_b = (opc == OP_REG) ? rs2v : imm_i;
    alt   = ir[30] && ((opc == OP_REG) || (f3 == 3'd5));
    shamt = alu_b[4:0];
    alu_y = '0;
    case (f3)
      3'd0: alu_y = alt ? rs1v - alu_b : rs1v + alu_b;
      3'd1: alu_y = rs1v << shamt;
      3'd2: alu_y = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'd3: alu_y = {31'b0, rs1v < alu_b};
      3'd4: alu_y = rs1v ^ alu_b;
      3'd5: alu_y = alt ? $unsigned($signed(rs1v) >>> shamt)
                        : rs1v >> shamt;
      3'd6: alu_y = rs1v | alu_b;
      3'd7: alu_y = rs1v & alu_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'd0: br_take = rs1v == rs2v;
      3'd1: br_take = rs1v != rs2v;
      3'd4: br_take = $signed(rs1v) < $signed(rs2v);
      3'd5: br_take = $signed(rs1v) >= $signed(rs2v);
      3'd6: br_take = rs1v < rs2v;
      3'd7: br_take = rs1v >= rs2v;
      default: br_take = 1'b0;
    endcase
  end

  // Execute-stage result and control
  always_comb begin
    wb_en  = 1'b0;
    wb_val = alu_y;
    pc_nx  = pc + 32'd4;
    mem_go = 1'b0;
    mem_we = 1'b0;
    ea     = rs1v + ((opc == OP_ST) ? imm_s : imm_i);
    unique case (1'b1)
      opc == OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      opc == OP_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc + imm_u;
      end
      opc == OP_JAL: begin
        wb_en  = 1'b1;
        wb_val = pc + 32'd4;
        pc_nx  = (pc + imm_j) & ~32'd1;
      end
      opc == OP_JALR && f3 == 3'd0: begin
        wb_en  = 1'b1;
        wb_val = pc + 32'd4;
        pc_nx  = (rs1v + imm_i) & ~32'd1;
      end
      opc == OP_BR && br_ok: begin
        if (br_take) pc_nx = (pc + imm_b) & ~32'd1;
      end
      opc == OP_LD && ld_ok: mem_go = 1'b1;
      opc == OP_ST && st_ok: begin
        mem_go = 1'b1;
        mem_we = 1'b1;
      end
      opc == OP_IMM && imm_ok: wb_en = 1'b1;
      opc == OP_REG && reg_ok: wb_en = 1'b1;
      default: ;
    endcase
  end

  // Store lanes; loads reuse the same SEL
  always_comb begin
    st_sel = 4'hF;
    st_dat = rs2v;
    case (f3[1:0])
      2'd0: begin
        st_sel = 4'b0001 << ea[1:0];
        st_dat = {4{rs2v[7:0]}};
      end
      2'd1: begin
        st_sel = ea[1] ? 4'b1100 : 4'b0011;
        st_dat = {2{rs2v[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction
  always_comb begin
    case (ea_lo)
      2'd0: ld_byte = dBusWishbone_DAT_MISO[7:0];
      2'd1: ld_byte = dBusWishbone_DAT_MISO[15:8];
      2'd2: ld_byte = dBusWishbone_DAT_MISO[23:16];
      default: ld_byte = dBusWishbone_DAT_MISO[31:24];
    endcase
    ld_half = ea_lo[1] ? dBusWishbone_DAT_MISO[31:16]
                       : dBusWishbone_DAT_MISO[15:0];
    case (f3)
      3'd0: ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1: ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4: ld_val = {24'b0, ld_byte};
      3'd5: ld_val = {16'b0, ld_half};
      default: ld_val = dBusWishbone_DAT_MISO;
    endcase
  end

  // Control state; i_req stays low for the first cycle after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= {externalResetVector, 2'b00};
      ir    <= NOP;
      i_req <= 1'b0;
      d_req <= 1'b0;
      d_we  <= 1'b0;
      d_adr <= '0;
      d_sel <= '0;
      d_dat <= '0;
      ea_lo <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!i_req) begin
            i_req <= 1'b1;
          end else if (i_done) begin
            ir    <= iBusWishbone_ACK ? iBusWishbone_DAT_MISO : NOP;
            i_req <= 1'b0;
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (mem_go) begin
            d_req <= 1'b1;
            d_we  <= mem_we;
            d_adr <= ea[31:2];
            d_sel <= st_sel;
            d_dat <= st_dat;
            ea_lo <= ea[1:0];
            state <= MEM;
          end else begin
            pc    <= pc_nx;
            i_req <= 1'b1;
            state <= FETCH;
          end
        end
        MEM: begin
          if (d_done) begin
            d_req <= 1'b0;
            d_we  <= 1'b0;
            pc    <= pc + 32'd4;
            i_req <= 1'b1;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Register file survives reset
  always_ff @(posedge clk) begin
    if (state == EXECUTE && wb_en && rd != 5'd0)
      regs[rd] <= wb_val;
    else if (state == MEM && d_done && !d_we && rd != 5'd0)
      regs[rd] <= dBusWishbone_ACK ? ld_val : 32'd0;
  end

endmodule

// File: tb/tb_riskv.sv
// tb_riskv: directed table-driven bench for riskv.
// Wishbone slave models with wait-state and error injection.
module tb_riskv;

  logic        clk;
  logic        rst;
  logic [29:0] i_adr;
  logic [31:0] i_mosi;
  logic [3:0]  i_sel;
  logic        i_cyc;
  logic        i_stb;
  logic        i_we;
  logic [2:0]  i_cti;
  logic [1:0]  i_bte;
  logic [31:0] i_miso;
  logic        i_ack;
  logic        i_err;
  logic [29:0] d_adr;
  logic [31:0] d_mosi;
  logic [3:0]  d_sel;
  logic        d_cyc;
  logic        d_stb;
  logic        d_we;
  logic [2:0]  d_cti;
  logic [1:0]  d_bte;
  logic [31:0] d_miso;
  logic        d_ack;
  logic        d_err;
  logic [29:0] rvec;

  riskv dut (
    .clk(clk), .rst(rst),
    .iBusWishbone_ADR(i_adr), .iBusWishbone_DAT_MOSI(i_mosi),
    .iBusWishbone_SEL(i_sel), .iBusWishbone_CYC(i_cyc),
    .iBusWishbone_STB(i_stb), .iBusWishbone_WE(i_we),
    .iBusWishbone_CTI(i_cti), .iBusWishbone_BTE(i_bte),
    .iBusWishbone_DAT_MISO(i_miso), .iBusWishbone_ACK(i_ack),
    .iBusWishbone_ERR(i_err),
    .dBusWishbone_ADR(d_adr), .dBusWishbone_DAT_MOSI(d_mosi),
    .dBusWishbone_SEL(d_sel), .dBusWishbone_CYC(d_cyc),
    .dBusWishbone_STB(d_stb), .dBusWishbone_WE(d_we),
    .dBusWishbone_CTI(d_cti), .dBusWishbone_BTE(d_bte),
    .dBusWishbone_DAT_MISO(d_miso), .dBusWishbone_ACK(d_ack),
    .dBusWishbone_ERR(d_err),
    .externalResetVector(rvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int          iwait = 0;
  int          icnt = 0;
  bit          ierr_en = 0;
  bit          both_en = 0;
  logic [29:0] ierr_adr = '0;
  bit          derr_en = 0;
  logic [29:0] derr_adr = '0;

  assign i_miso = imem[i_adr[7:0]];
  assign i_err  = i_stb && ierr_en && (i_adr == ierr_adr);
  assign i_ack  = i_stb && (icnt >= iwait) && (!i_err || both_en);
  assign d_miso = dmem[d_adr[7:0]];
  assign d_err  = d_stb && derr_en && !d_we && (d_adr == derr_adr);
  assign d_ack  = d_stb && !d_err;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    icnt  <= (i_stb && !i_ack && !i_err) ? icnt + 1 : 0;
  end

  logic        lg_we;
  logic [29:0] lg_adr;
  logic [3:0]  lg_sel;
  logic [31:0] lg_dat;

  always @(posedge clk) begin
    if (!rst && d_stb && d_ack && d_we) begin
      for (int b = 0; b < 4; b++)
        if (d_sel[b]) dmem[d_adr[7:0]][8*b +: 8] = d_mosi[8*b +: 8];
      lg_we  = d_we;
      lg_adr = d_adr;
      lg_sel = d_sel;
      lg_dat = d_mosi;
    end
  end

  logic [29:0] fa [$];
  int          ft [$];
  logic        p_stb = 0;
  logic        p_term = 0;
  logic [29:0] p_adr = '0;

  always @(posedge clk) begin
    if (rst) begin
      p_stb = 0;
    end else begin
      if (i_cyc && d_cyc) begin
        errors++;
        $display("FAIL bus_overlap: i_cyc=%b d_cyc=%b expected not both",
                 i_cyc, d_cyc);
      end
      if (p_stb && !p_term) begin
        checks++;
        if (!i_stb || i_adr != p_adr) begin
          errors++;
          $display("FAIL ibus_hold: stb=%b adr=%h expected stb=1 adr=%h",
                   i_stb, i_adr, p_adr);
        end
      end
      if (i_stb && (i_ack || i_err)) begin
        fa.push_back(i_adr);
        ft.push_back(cyc_n);
      end
      p_stb  = i_stb;
      p_term = i_ack || i_err;
      p_adr  = i_adr;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm,
      input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm,
      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) begin
      imem[k] = 32'h0000_0013;
      dmem[k] = 32'h0;
    end
  endtask

  task automatic hold_reset(input logic [29:0] vec);
    @(negedge clk);
    rvec = vec;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    fa.delete();
    ft.delete();
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e3;
    logic [31:0] e4;
  } vec_t;

  vec_t tv [$];

  initial begin
    rst  = 1'b1;
    rvec = '0;
    lg_we = 0; lg_adr = '0; lg_sel = '0; lg_dat = '0;
    clear_mem();

    // x1=a, x2=b, x3 preset 0x55, x4 set 0x66 unless skipped
    tv.push_back('{"add",  enc_r(7'h00,2,1,3'd0,3), 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h66});
    tv.push_back('{"addwr",enc_r(7'h00,2,1,3'd0,3), 32'hFFFFFFFF, 32'd1, 32'h0, 32'h66});
    tv.push_back('{"sub",  enc_r(7'h20,2,1,3'd0,3), 32'd3, 32'd5, 32'hFFFFFFFE, 32'h66});
    tv.push_back('{"sll",  enc_r(7'h00,2,1,3'd1,3), 32'd1, 32'd33, 32'd2, 32'h66});
    tv.push_back('{"slt",  enc_r(7'h00,2,1,3'd2,3), 32'hFFFFFFFF, 32'd1, 32'd1, 32'h66});
    tv.push_back('{"sltu", enc_r(7'h00,2,1,3'd3,3), 32'hFFFFFFFF, 32'd1, 32'd0, 32'h66});
    tv.push_back('{"xor",  enc_r(7'h00,2,1,3'd4,3), 32'hF0F0, 32'hFF00, 32'h0FF0, 32'h66});
    tv.push_back('{"srl",  enc_r(7'h00,2,1,3'd5,3), 32'h80000000, 32'd4, 32'h08000000, 32'h66});
    tv.push_back('{"sra",  enc_r(7'h20,2,1,3'd5,3), 32'h80000000, 32'd4, 32'hF8000000, 32'h66});
    tv.push_back('{"or",   enc_r(7'h00,2,1,3'd6,3), 32'h0F, 32'hF0, 32'hFF, 32'h66});
    tv.push_back('{"and",  enc_r(7'h00,2,1,3'd7,3), 32'hFF, 32'h0F, 32'h0F, 32'h66});
    tv.push_back('{"addi", enc_i(12'hFFF,1,3'd0,3,7'h13), 32'd0, 32'd0, 32'hFFFFFFFF, 32'h66});
    tv.push_back('{"srai", enc_i(12'h41F,1,3'd5,3,7'h13), 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h66});
    tv.push_back('{"slli", enc_i(12'h004,1,3'd1,3,7'h13), 32'd3, 32'd0, 32'h30, 32'h66});
    tv.push_back('{"slti", enc_i(12'hFFE,1,3'd2,3,7'h13), 32'hFFFFFFFF, 32'd0, 32'd0, 32'h66});
    tv.push_back('{"sltiu",enc_i(12'hFFF,1,3'd3,3,7'h13), 32'd5, 32'd0, 32'd1, 32'h66});
    tv.push_back('{"xori", enc_i(12'hFFF,1,3'd4,3,7'h13), 32'h0F, 32'd0, 32'hFFFFFFF0, 32'h66});
    tv.push_back('{"lui",  enc_u(20'h12345,3,7'h37), 32'd0, 32'd0, 32'h12345000, 32'h66});
    tv.push_back('{"auipc",enc_u(20'h00001,3,7'h17), 32'd0, 32'd0, 32'h00001010, 32'h66});
    tv.push_back('{"jal",  enc_j(21'd8,3), 32'd0, 32'd0, 32'd20, 32'd0});
    tv.push_back('{"jalr", enc_i(12'h003,1,3'd0,3,7'h67), 32'd22, 32'd0, 32'd20, 32'd0});
    tv.push_back('{"beq",  enc_b(13'd8,2,1,3'd0), 32'd7, 32'd7, 32'h55, 32'd0});
    tv.push_back('{"bne",  enc_b(13'd8,2,1,3'd1), 32'd7, 32'd7, 32'h55, 32'h66});
    tv.push_back('{"blt",  enc_b(13'd8,2,1,3'd4), 32'hFFFFFFFF, 32'd1, 32'h55, 32'd0});
    tv.push_back('{"bge",  enc_b(13'd8,2,1,3'd5), 32'hFFFFFFFF, 32'd1, 32'h55, 32'h66});
    tv.push_back('{"bltu", enc_b(13'd8,2,1,3'd6), 32'hFFFFFFFF, 32'd1, 32'h55, 32'h66});
    tv.push_back('{"bgeu", enc_b(13'd8,2,1,3'd7), 32'hFFFFFFFF, 32'd1, 32'h55, 32'd0});
    tv.push_back('{"ecall",32'h00000073, 32'd1, 32'd2, 32'h55, 32'h66});
    tv.push_back('{"unk",  32'h0000000B, 32'd1, 32'd2, 32'h55, 32'h66});
    tv.push_back('{"badf7",enc_r(7'h01,2,1,3'd0,3), 32'd1, 32'd2, 32'h55, 32'h66});

    // Basic program, reset state and fetch spacing
    repeat (2) @(negedge clk);
    imem[0] = enc_i(12'h005,0,3'd0,1,7'h13);
    imem[1] = enc_i(12'hFF9,1,3'd0,2,7'h13);
    imem[2] = enc_r(7'h00,2,1,3'd0,3);
    imem[3] = enc_s(12'h200,1,0,3'd2);
    imem[4] = enc_s(12'h204,2,0,3'd2);
    imem[5] = enc_s(12'h208,3,0,3'd2);
    imem[6] = enc_j(21'd0,0);
    chk1("rst_icyc", i_cyc, 1'b0);
    chk1("rst_istb", i_stb, 1'b0);
    chk1("rst_dcyc", d_cyc, 1'b0);
    chk1("rst_dwe", d_we, 1'b0);
    chk("rst_dadr", {2'b0, d_adr}, 32'h0);
    chk("rst_dsel", {28'b0, d_sel}, 32'h0);
    chk("rst_ddat", d_mosi, 32'h0);
    chk("rst_isel", {28'b0, i_sel}, 32'hF);
    rst = 1'b0;
    #1;
    chk1("rel_icyc", i_cyc, 1'b0);
    run(40);
    if (fa.size() < 5) begin
      chk("basic_nfetch", fa.size(), 5);
    end else begin
      chk("basic_fa0", {2'b0, fa[0]}, 32'd0);
      chk("basic_fa1", {2'b0, fa[1]}, 32'd1);
      chk("basic_fa2", {2'b0, fa[2]}, 32'd2);
      chk("basic_gap1", ft[1] - ft[0], 32'd2);
      chk("basic_gap2", ft[2] - ft[1], 32'd2);
      chk("basic_stgap", ft[4] - ft[3], 32'd3);
    end
    chk("basic_x1", dmem[8'h80], 32'd5);
    chk("basic_x2", dmem[8'h81], 32'hFFFFFFFE);
    chk("basic_x3", dmem[8'h82], 32'd3);

    // Boot vector 0x100
    hold_reset(30'h100);
    chk("rst_iadr", {2'b0, i_adr}, 32'h100);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("vec_icyc", i_cyc, 1'b1);
    chk1("vec_istb", i_stb, 1'b1);
    chk("vec_iadr", {2'b0, i_adr}, 32'h100);

    // Table: one instruction in a fixed harness
    foreach (tv[k]) begin
      hold_reset(30'h0);
      clear_mem();
      imem[0] = enc_i(12'h100,0,3'd2,1,7'h03);
      imem[1] = enc_i(12'h104,0,3'd2,2,7'h03);
      imem[2] = enc_i(12'h055,0,3'd0,3,7'h13);
      imem[3] = enc_i(12'h000,0,3'd0,4,7'h13);
      imem[4] = tv[k].ins;
      imem[5] = enc_i(12'h066,0,3'd0,4,7'h13);
      imem[6] = enc_s(12'h108,3,0,3'd2);
      imem[7] = enc_s(12'h10C,4,0,3'd2);
      imem[8] = enc_j(21'd0,0);
      dmem[8'h40] = tv[k].a;
      dmem[8'h41] = tv[k].b;
      dmem[8'h42] = 32'hDEADBEEF;
      dmem[8'h43] = 32'hDEADBEEF;
      rst = 1'b0;
      run(40);
      chk({tv[k].name, "_x3"}, dmem[8'h42], tv[k].e3);
      chk({tv[k].name, "_x4"}, dmem[8'h43], tv[k].e4);
    end

    // Byte store lanes
    hold_reset(30'h0);
    clear_mem();
    imem[0] = enc_i(12'h100,0,3'd2,1,7'h03);
    imem[1] = enc_s(12'h003,1,0,3'd0);
    imem[2] = enc_j(21'd0,0);
    dmem[8'h40] = 32'h1234ABCD;
    rst = 1'b0;
    run(20);
    chk1("sb_we", lg_we, 1'b1);
    chk("sb_adr", {2'b0, lg_adr}, 32'h0);
    chk("sb_sel", {28'b0, lg_sel}, 32'h8);
    chk("sb_dat", lg_dat, 32'hCDCDCDCD);
    chk("sb_mem", dmem[0], 32'hCD000000);

    // Sub-word loads
    hold_reset(30'h0);
    clear_mem();
    imem[0]  = enc_i(12'h002,0,3'd1,5,7'h03);
    imem[1]  = enc_i(12'h002,0,3'd5,6,7'h03);
    imem[2]  = enc_i(12'h003,0,3'd0,7,7'h03);
    imem[3]  = enc_i(12'h003,0,3'd4,8,7'h03);
    imem[4]  = enc_i(12'h002,0,3'd0,10,7'h03);
    imem[5]  = enc_s(12'h108,5,0,3'd2);
    imem[6]  = enc_s(12'h10C,6,0,3'd2);
    imem[7]  = enc_s(12'h110,7,0,3'd2);
    imem[8]  = enc_s(12'h114,8,0,3'd2);
    imem[9]  = enc_s(12'h118,10,0,3'd2);
    imem[10] = enc_j(21'd0,0);
    dmem[0] = 32'h80010000;
    rst = 1'b0;
    run(50);
    chk("lh", dmem[8'h42], 32'hFFFF8001);
    chk("lhu", dmem[8'h43], 32'h00008001);
    chk("lb", dmem[8'h44], 32'hFFFFFF80);
    chk("lbu", dmem[8'h45], 32'h00000080);
    chk("lb2", dmem[8'h46], 32'h00000001);

    // Backward branch at PC 8
    hold_reset(30'h0);
    clear_mem();
    imem[2] = enc_b(13'h1FFC,0,0,3'd0);
    rst = 1'b0;
    run(12);
    if (fa.size() < 4) chk("beq_nfetch", fa.size(), 4);
    else chk("beq_fa3", {2'b0, fa[3]}, 32'd1);

    // jal x1,+16
    hold_reset(30'h0);
    clear_mem();
    imem[0] = enc_j(21'd16,1);
    imem[4] = enc_s(12'h108,1,0,3'd2);
    imem[5] = enc_j(21'd0,0);
    rst = 1'b0;
    run(15);
    if (fa.size() < 2) chk("jal_nfetch", fa.size(), 2);
    else chk("jal_fa1", {2'b0, fa[1]}, 32'd4);
    chk("jal_x1", dmem[8'h42], 32'd4);

    // Three iBus wait states
    hold_reset(30'h0);
    clear_mem();
    iwait = 3;
    imem[0] = enc_i(12'h005,0,3'd0,1,7'h13);
    imem[1] = enc_i(12'hFF9,1,3'd0,2,7'h13);
    imem[2] = enc_r(7'h00,2,1,3'd0,3);
    imem[3] = enc_s(12'h208,3,0,3'd2);
    imem[4] = enc_j(21'd0,0);
    rst = 1'b0;
    run(60);
    if (ft.size() < 2) chk("ws_nfetch", ft.size(), 2);
    else chk("ws_gap", ft[1] - ft[0], 32'd5);
    chk("ws_x3", dmem[8'h82], 32'd3);
    iwait = 0;

    // Data ERR on load
    hold_reset(30'h0);
    clear_mem();
    imem[0] = enc_i(12'h009,0,3'd0,6,7'h13);
    imem[1] = enc_i(12'h100,0,3'd2,6,7'h03);
    imem[2] = enc_s(12'h108,6,0,3'd2);
    imem[3] = enc_j(21'd0,0);
    dmem[8'h40] = 32'h12345678;
    dmem[8'h42] = 32'hFFFFFFFF;
    derr_en = 1; derr_adr = 30'h40;
    rst = 1'b0;
    run(20);
    chk("derr_x6", dmem[8'h42], 32'd0);
    derr_en = 0;

    // iBus ERR gives NOP; ACK+ERR lets ACK win
    for (int m = 0; m < 2; m++) begin
      hold_reset(30'h0);
      clear_mem();
      imem[0] = enc_i(12'h055,0,3'd0,3,7'h13);
      imem[1] = enc_i(12'h011,0,3'd0,3,7'h13);
      imem[2] = enc_s(12'h108,3,0,3'd2);
      imem[3] = enc_j(21'd0,0);
      ierr_en = 1; ierr_adr = 30'h1; both_en = (m == 1);
      rst = 1'b0;
      run(20);
      chk(m == 0 ? "ierr_x3" : "ackerr_x3", dmem[8'h42],
          m == 0 ? 32'h55 : 32'h11);
    end
    ierr_en = 0; both_en = 0;

    // Reset mid-fetch; register file survives
    hold_reset(30'h0);
    clear_mem();
    imem[0] = enc_i(12'h03C,0,3'd0,9,7'h13);
    imem[1] = enc_j(21'd0,0);
    rst = 1'b0;
    run(10);
    iwait = 3;
    for (int w = 0; w < 10 && !i_stb; w++) @(negedge clk);
    chk1("mid_stb_pre", i_stb, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_icyc", i_cyc, 1'b0);
    chk1("mid_istb", i_stb, 1'b0);
    iwait = 0;
    imem[0] = enc_s(12'h108,9,0,3'd2);
    imem[1] = enc_j(21'd0,0);
    hold_reset(30'h0);
    rst = 1'b0;
    run(20);
    if (fa.size() < 1) chk("mid_nfetch", fa.size(), 1);
    else chk("mid_fa0", {2'b0, fa[0]}, 32'd0);
    chk("mid_x9", dmem[8'h42], 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riskv.md
# riskv

Minimal multi-cycle RV32I processor core with separate Wishbone B4 classic instruction and data masters. Sits at the top of the CPU subsystem: fetches from the iBus, executes loads and stores on the dBus, and starts from a boot address supplied on `externalResetVector`. No interrupts, CSRs or caches.

## Interface
- No parameters.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `iBusWishbone_ADR` out 30: instruction word address, PC[31:2].
- `iBusWishbone_DAT_MOSI` out 32: always 0.
- `iBusWishbone_SEL` out 4: always 4'hF.
- `iBusWishbone_CYC`, `iBusWishbone_STB` out 1: fetch request; both driven identically.
- `iBusWishbone_WE` out 1: always 0.
- `iBusWishbone_CTI` out 3: always 3'b000 (classic).
- `iBusWishbone_BTE` out 2: always 2'b00.
- `iBusWishbone_DAT_MISO` in 32: instruction word.
- `iBusWishbone_ACK`, `iBusWishbone_ERR` in 1: cycle termination.
- `dBusWishbone_ADR` out 30: data word address, EA[31:2].
- `dBusWishbone_DAT_MOSI` out 32: store data, lane-replicated.
- `dBusWishbone_SEL` out 4: byte lane enables.
- `dBusWishbone_CYC`, `dBusWishbone_STB` out 1: data request; driven identically.
- `dBusWishbone_WE` out 1: 1 for stores.
- `dBusWishbone_CTI` out 3: always 3'b000. `dBusWishbone_BTE` out 2: always 2'b00.
- `dBusWishbone_DAT_MISO` in 32, `dBusWishbone_ACK` in 1, `dBusWishbone_ERR` in 1.
- `externalResetVector` in 30: boot word address; sampled while `rst` is high.

## Operation
- State: PC (32 bits), IR (32 bits), 31 general registers x1..x31; x0 reads 0 and ignores writes. The register file is not reset.
- FSM states:
  - FETCH: CYC=STB=1, ADR=PC[31:2]. On ACK, latch IR, go to EXECUTE. On ERR, load IR with NOP (32'h00000013), go to EXECUTE.
  - EXECUTE: decode IR, read rs1/rs2, compute. ALU ops, LUI, AUIPC, JAL, JALR and branches write rd, update PC and return to FETCH. Loads and stores compute EA = rs1 + sext(imm) and go to MEM.
  - MEM: dBus CYC=STB=1 until ACK or ERR. A load writes rd on ACK; on ERR rd is written 0. A store writes nothing. Then PC += 4 and return to FETCH.
- Supported instructions: full RV32I (LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP).
- FENCE, ECALL, EBREAK and all unrecognised encodings execute as NOP: PC += 4, no register write.
- Shifts use rs2[4:0] or shamt[4:0]. SRA/SRAI are selected by IR[30]. Arithmetic wraps modulo 2^32.
- Jump and branch targets have bit 0 cleared. Target bit 1 is not checked, so there is no misalignment trap.
- JAL/JALR write PC+4 to rd. JALR with rd == rs1 uses the old rs1 value.
- Byte store: SEL = 1 << EA[1:0], data = {4{rs2[7:0]}}.
- Halfword store: SEL = EA[1] ? 4'b1100 : 4'b0011, data = {2{rs2[15:0]}}. EA[0] is ignored.
- Word store: SEL = 4'hF. EA[1:0] are ignored.
- Loads use the same SEL as the matching store width. The byte or half is extracted from the selected lane, then sign- or zero-extended.
- Load SEL is informative only: slaves may return a full word.

## Timing
- During `rst` and in the first cycle after release:
  - All CYC, STB and WE outputs are 0.
  - `dBusWishbone_ADR`, SEL and DAT_MOSI are 0.
  - PC = {externalResetVector, 2'b00}; FSM = FETCH.
- `iBusWishbone_ADR` during reset equals `externalResetVector`.
- The first fetch request is asserted in the first rising edge's cycle after `rst` deasserts.
- ACK/ERR is sampled on the rising edge while STB is high. Zero-wait slaves may assert ACK combinationally in the same cycle as STB.
- The request is held stable, with ADR/SEL/DAT/WE unchanged, until termination. CYC/STB drop in the cycle after termination.
- With zero-wait slaves: non-memory instruction = 2 cycles; load or store = 3 cycles. Each wait state adds 1 cycle.
- The next fetch begins the cycle after EXECUTE (non-memory) or after MEM termination.
- ACK and ERR together: ACK wins.
- ACK/ERR while STB=0 is ignored.
- iBus and dBus are never active in the same cycle.
- Asserting `rst` mid-transaction drops CYC/STB immediately, with no completion. The register file is preserved.

## Test plan
- Reset vector 0, zero-wait memory holding `addi x1,x0,5; addi x2,x1,-7; add x3,x1,x2` -> fetch addresses 0,1,2; x1=5, x2=0xFFFFFFFE, x3=3; fetches spaced 2 cycles.
- `externalResetVector`=30'h100 -> first iBus ADR 30'h100 in the first cycle after reset, CYC=STB=1.
- `sb x1,3(x0)` with x1=0x1234ABCD -> dBus WE=1, ADR=0, SEL=4'b1000, DAT_MOSI=0xCDCDCDCD.
- `lh x5,2(x0)` with memory word 0x8001_0000 -> x5=0xFFFF8001.
- `lhu` of the same word -> x5=0x00008001.
- `beq x0,x0,-4` at PC 8 -> next fetch ADR 1, no register writes.
- `jal x1,+16` at PC 0 -> x1=4, next ADR 4.
- iBus slave with 3 wait states -> ADR/STB stable for 4 cycles, execution correct.
- Data ERR on `lw x6` -> x6=0.
- `rst` asserted mid-fetch -> CYC/STB fall asynchronously; refetch from the reset vector after release.
